// File: rtl/eb_serializer_if.sv
// eb_serializer_if
//
// Purpose: valid/ready stream bundle used on both sides of eb_serializer.
//          One instance carries the wide upstream words (t_0). A second
//          instance carries the narrow downstream beats (i_0).
//
// Parameters:
//   WIDTH  data width of this stream (bits)
//
// Signals:
//   data   payload, driven by the master
//   valid  payload valid, driven by the master
//   ready  sink accepts payload, driven by the slave
//   last   final beat of a packet, driven by the master
//          (present only when EB_SER_LAST_EN is defined)
//
// Modports:
//   master  producer side (drives data/valid[/last], samples ready)
//   slave   consumer side (samples data/valid, drives ready)
//
// Configuration macro: EB_SER_LAST_EN

interface eb_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
`ifdef EB_SER_LAST_EN
  logic             last;
`endif

`ifdef EB_SER_LAST_EN
  modport master (output data, output valid, output last, input ready);
`else
  modport master (output data, output valid, input ready);
`endif

  // The slave side never looks at last. The wide upstream stream has no
  // packet framing.
  modport slave (input data, input valid, output ready);

endinterface

// File: rtl/eb_serializer.sv
// eb_serializer
//
// Purpose: elastic width-downsizing stage. It accepts one wide word per t_0
//          handshake. It then emits that word as RATIO narrow beats on i_0,
//          least-significant slice first. A new word can be taken in the
//          same cycle that the last beat leaves, so i_0 can sustain one beat
//          per cycle.
//
// Parameters:
//   DWIDTH  width of one output beat (bits)
//   RATIO   beats per input word, legal range 2..256
//
// Ports:
//   clk      in      rising-edge clock
//   reset_n  in      asynchronous, active-low reset
//   t_0      slave   wide input stream (DWIDTH*RATIO bits): data, valid, ready
//   i_0      master  narrow output stream (DWIDTH bits): data, valid, ready
//                    and last (last only with EB_SER_LAST_EN)
//
// Configuration macro: EB_SER_LAST_EN
//   defined   -> i_0.last flags the final beat of each word
//   undefined -> no last signal; all other behaviour is identical

module eb_serializer #(
  parameter int DWIDTH = 8,
  parameter int RATIO  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  eb_serializer_if.slave         t_0,
  eb_serializer_if.master        i_0
);

  localparam int CW = $clog2(RATIO);

  typedef enum logic {
    EMPTY,
    BUSY
  } state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [RATIO-1:0][DWIDTH-1:0]  word_q, word_d;

  logic                          last_beat;
  logic                          take_word;

  // The counter only ever returns to zero through last_beat. Because of
  // that, values of RATIO or above cannot occur, even when RATIO is not a
  // power of two.
  assign last_beat = (state_q == BUSY) && (cnt_q == CW'(RATIO - 1));

  // The ready path from i_0 to t_0 is combinational on purpose. It lets the
  // next word load in the same cycle that the last beat drains.
  assign t_0.ready = (state_q == EMPTY) || (last_beat && i_0.ready);
  assign take_word = t_0.valid && t_0.ready;

  assign i_0.valid = (state_q == BUSY);
  assign i_0.data  = word_q[cnt_q];

`ifdef EB_SER_LAST_EN
  assign i_0.last  = last_beat;
`endif

  // State register, beat counter and holding register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  // Next-state logic. When draining to EMPTY, the old word is left in the
  // holding register; only the counter is cleared.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      EMPTY: begin
        if (take_word) begin
          word_d  = t_0.data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_0.ready) begin
          if (!last_beat) begin
            cnt_d = cnt_q + CW'(1);
          end else if (take_word) begin
            word_d = t_0.data;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
